squarer_frame_accumulator: RTL
==============================

Name: squarer_frame_accumulator

Overview:
- Sequential stage directly downstream of squarer_4bit. It consumes a stream of 4-bit operands and the squarer's 8-bit result, and produces one sum of squares per frame of FRAME_LEN samples.
- It feeds the registered operand to squarer_4bit through sq_a and reads sq_y back combinationally. The squarer's garbage buses stay unconnected at this level.
- Input and output are valid/ready handshaked. Used for energy/variance estimation over reversible-logic squarer outputs.

Parameters:
- FRAME_LEN, 8, samples per frame; range 1..255.
- ACC_W, 16, accumulator and out_sum width; must be >= 8.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous frame abort: drops the partial frame, returns to ACCUM with empty state.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid & in_ready.
- in_a  input  4  unsigned operand.
- sq_a  output  4  operand to squarer_4bit.a; always equals a_q.
- sq_y  input  8  squarer_4bit.Y (combinational from sq_a).
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  sum of squares of the frame.
- out_ovf  output  1  accumulator overflowed (or saturated) during this frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACCUM; a_q=0; pend_q=0; cnt=0; acc=0; ovf=0.
  - Outputs: in_ready=0 while rst_n is low, then 1 from the first clock after release; out_valid=0; out_sum=0; out_ovf=0; sq_a=0.
- States:
  - ACCUM: in_ready = (cnt < FRAME_LEN).
  - FINISH: in_ready=0; one-cycle drain of the last pending add.
  - DONE: in_ready=0; out_valid=1; out_sum=acc; out_ovf=ovf.
- Accept (ACCUM, in_valid & in_ready): a_q<=in_a; pend_q<=1; cnt<=cnt+1.
- No accept: pend_q<=0; a_q holds.
- Add: every cycle with pend_q=1, acc<=acc+zero_ext(sq_y) and ovf<=ovf|carry_out. An add and a new accept occur in the same cycle, so throughput is one sample per clock.
- Latency: the sample accepted at edge t is added at edge t+1.
- Transitions:
  - ACCUM->FINISH on the edge that accepts sample FRAME_LEN (cnt becomes FRAME_LEN).
  - FINISH->DONE on the next edge; the final add lands on this edge.
  - out_valid rises 2 edges after the last accept.
- DONE handshake:
  - out_valid, out_sum and out_ovf are held stable until out_ready.
  - On the out_valid & out_ready edge: acc=0, ovf=0, cnt=0, state=ACCUM; in_ready rises the next cycle.
  - out_ready while out_valid=0 is ignored.
- clr:
  - Has priority over accept, add and DONE handshake: acc, cnt, pend_q and ovf are cleared and state goes to ACCUM.
  - A result in DONE is discarded by clr.
- Width rules: squares are 0..225, unsigned. Wrap is modulo 2^ACC_W; ovf is sticky per frame.
- Boundary cases:
  - FRAME_LEN=1: ACCUM->FINISH on the first accept.
  - in_valid held high with out_ready low: no accept beyond FRAME_LEN, no data loss, no duplicate.
  - Asynchronous reset mid-frame: the partial frame is lost and out_valid drops immediately.

Optional Feature:
- Macro SQ_ACC_SATURATE_EN.
- When defined: an add that would carry out clamps acc to 2^ACC_W-1, sets ovf, and holds acc at the clamp for the rest of the frame.
- When undefined: modulo wrap as above, with ovf still flagged.

Test Plan:
- FRAME_LEN=8, in_a=0..7 streamed back-to-back, out_ready=1 -> out_sum=140, out_ovf=0; out_valid exactly 2 cycles after the 8th accept; in_ready=0 during FINISH/DONE.
- FRAME_LEN=8, eight samples of 15, out_ready low for 5 cycles -> out_sum=1800 (0x708) held stable for all 5 cycles; in_ready=0 throughout; next frame starts with acc=0.
- ACC_W=10, FRAME_LEN=8, eight samples of 15 -> out_sum=776, out_ovf=1 (wrap build); out_sum=1023, out_ovf=1 with SQ_ACC_SATURATE_EN.
- Gapped input: in_valid toggling 1,0,1,0 with in_a=3,x,4,x..., FRAME_LEN=2 -> out_sum=25; no sample added twice.
- rst_n low after 3 of 8 samples, then a full frame of 2s -> out_valid=0 during reset; result=32, not 44.
- clr asserted while in DONE holding 140 -> out_valid falls next cycle, in_ready=1, next frame of 1s sums to 8.

Source files
------------

// File: rtl/squarer_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : squarer_frame_accumulator
//  Purpose  : Sums the squares of a stream of 4-bit operands over frames of
//             FRAME_LEN samples. The accepted operand is registered and sent
//             to an external squarer_4bit on sq_a. Its product comes back on
//             sq_y and is added on the following edge, so one sample can be
//             taken per clock.
//  Ports    : clk, rst_n (async, active low), clr (sync frame abort)
//             in_valid / in_ready / in_a      - operand stream
//             sq_a / sq_y                     - squarer_4bit link
//             out_valid / out_ready / out_sum / out_ovf - frame result
//  Options  : SQ_ACC_SATURATE_EN - clamp the accumulator at 2^ACC_W-1
//             instead of wrapping. out_ovf is set in both builds.
//  Revision : 1.0 - initial release
// ============================================================================
module squarer_frame_accumulator #(
    parameter int FRAME_LEN = 8,   // samples per frame, 1..255
    parameter int ACC_W     = 16   // accumulator width, >= 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    output logic [3:0]       sq_a,
    input  logic [7:0]       sq_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_FINISH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] C_FRAME_LEN = 8'(FRAME_LEN);
    localparam logic [7:0] C_LAST_IDX  = 8'(FRAME_LEN - 1);

    state_t           r_state;
    logic [3:0]       r_a;
    logic             r_pend;
    logic [7:0]       r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    // Holds in_ready low until the first clock edge after reset release.
    logic             r_run;

    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;

    assign in_ready  = r_run && (r_state == ST_ACCUM) && (r_cnt < C_FRAME_LEN);
    assign w_accept  = in_valid && in_ready;
    assign sq_a      = r_a;
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = out_valid ? r_acc : '0;
    assign out_ovf   = out_valid && r_ovf;

    // One extra bit on the adder exposes the carry out of the accumulator.
    assign w_sum   = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, sq_y};
    assign w_carry = w_sum[ACC_W];

`ifdef SQ_ACC_SATURATE_EN
    // Once clamped, every further non-zero add carries again, so the value
    // stays pinned at the maximum until the frame ends.
    assign w_acc_next = w_carry ? '1 : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_a     <= 4'd0;
            r_pend  <= 1'b0;
            r_cnt   <= 8'd0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (clr) begin
                // Abort wins over accept, add and the result handshake.
                r_state <= ST_ACCUM;
                r_pend  <= 1'b0;
                r_cnt   <= 8'd0;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_pend <= w_accept;
                if (w_accept) begin
                    r_a   <= in_a;
                    r_cnt <= r_cnt + 8'd1;
                end

                // sq_y belongs to the sample accepted on the previous edge.
                if (r_pend) begin
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_carry;
                end

                case (r_state)
                    ST_ACCUM: begin
                        if (w_accept && (r_cnt == C_LAST_IDX)) begin
                            r_state <= ST_FINISH;
                        end
                    end
                    ST_FINISH: begin
                        // Final add of the frame lands on this edge.
                        r_state <= ST_DONE;
                    end
                    ST_DONE: begin
                        // No add is pending here, so clearing is safe.
                        if (out_ready) begin
                            r_state <= ST_ACCUM;
                            r_cnt   <= 8'd0;
                            r_acc   <= '0;
                            r_ovf   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_ACCUM;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
